c_detect_sched: RTL and testbench

- Count-domain (c_clk, 460 MHz) scheduler that shares the single cdc_c2g crossing between NCH micromotion_detect channels.
- Each channel's detect pulse and its diff/count data are captured into a one-deep per-channel holding slot.
- A round-robin arbiter issues one event at a time to cdc_c2g, spaced so that cdc_c2g is always back in WAIT when the next pulse arrives. No event is silently lost; losses are flagged.
- Sits between the micromotion_detect instances and cdc_c2g.

---
 rtl/c_sched_pkg.sv | 6 +
 rtl/c_detect_sched_arb.sv | 26 ++
 rtl/c_detect_sched.sv | 119 +++++++++++
 tb/tb_c_detect_sched.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/c_sched_pkg.sv
// c_sched_pkg: shared state encoding and constants for the detect scheduler
package c_sched_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, GAP = 2'd2} state_t;
  localparam int CDC_OCCUPANCY = 14;
  localparam int GAP_CW = 8;
endpackage

// File: rtl/c_detect_sched_arb.sv
// rr_arbiter: combinational round-robin grant, search starts just after last
module rr_arbiter #(
  parameter int NCH = 4,
  localparam int CHW = $clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [CHW-1:0] last,
  output logic           gnt_valid,
  output logic [CHW-1:0] gnt_idx
);
  logic [CHW-1:0] sh, p;
  logic [2*NCH-1:0] dbl;
  logic [NCH-1:0] rot;
  logic [CHW:0] sum;
  assign sh = (last == CHW'(NCH - 1)) ? '0 : last + CHW'(1);
  assign dbl = {req, req};
  assign rot = dbl[sh +: NCH];
  // lowest set bit of the rotated request vector
  always_comb begin
    p = '0;
    for (int i = NCH - 1; i >= 0; i--) if (rot[i]) p = CHW'(i);
  end
  assign sum = {1'b0, sh} + {1'b0, p};
  assign gnt_idx = (sum >= (CHW + 1)'(NCH)) ? CHW'(sum - (CHW + 1)'(NCH)) : sum[CHW-1:0];
  assign gnt_valid = |req;
endmodule

// File: rtl/c_detect_sched.sv
// c_detect_sched: shares one cdc_c2g crossing among NCH detect channels
module c_detect_sched
  import c_sched_pkg::*;
#(
  parameter int NCH = 4,
  parameter int DATASIZE = 16,
  parameter int COUNTSIZE = 32,
  parameter int ISSUE_GAP = CDC_OCCUPANCY,
  localparam int CHW = $clog2(NCH)
) (
  input  logic                     c_clk,
  input  logic                     c_rst,
  input  logic [NCH-1:0]           c_detect,
  input  logic [NCH*DATASIZE-1:0]  c_diff,
  input  logic [NCH*COUNTSIZE-1:0] c_diff_count,
  input  logic [NCH-1:0]           c_chan_en,
  input  logic                     c_ovf_clr,
  output logic                     c_detect_out,
  output logic [DATASIZE-1:0]      c_diff_out,
  output logic [COUNTSIZE-1:0]     c_diff_count_out,
  output logic [CHW-1:0]           c_chan_out,
  output logic [NCH-1:0]           c_overflow,
  output logic                     c_busy
);
  if (ISSUE_GAP < 2 || ISSUE_GAP > 255) begin : g_gap_chk
    $error("ISSUE_GAP must be within 2..255");
  end
  state_t state_q, state_d;
  logic [GAP_CW-1:0] cnt_q, cnt_d;
  logic [CHW-1:0] rr_q, rr_d, chan_q, chan_d, gnt_idx;
  logic det_q, det_d, gnt_valid, fire;
  logic [DATASIZE-1:0] dout_q, dout_d;
  logic [COUNTSIZE-1:0] cout_q, cout_d;
  logic [NCH-1:0] pend_q, pend_d, ovf_q, ovf_d, gnt_oh, hit, cap;
  logic [DATASIZE-1:0] sd_q [NCH];
  logic [COUNTSIZE-1:0] sc_q [NCH];
  rr_arbiter #(.NCH(NCH)) u_arb (
    .req(pend_q), .last(rr_q), .gnt_valid(gnt_valid), .gnt_idx(gnt_idx)
  );
  assign fire = (state_q == IDLE) && gnt_valid;
  assign gnt_oh = fire ? ({{(NCH-1){1'b0}}, 1'b1} << gnt_idx) : '0;
  assign hit = c_detect & c_chan_en;
  assign cap = hit & (~pend_q | gnt_oh);
  assign pend_d = cap | (pend_q & ~gnt_oh);
  assign ovf_d = (c_ovf_clr ? '0 : ovf_q) | (hit & pend_q & ~gnt_oh);
  // per-channel holding slots; a slot being granted may be refilled at once
  always_ff @(posedge c_clk or posedge c_rst) begin
    if (c_rst) begin
      pend_q <= '0;
      ovf_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        sd_q[i] <= '0;
        sc_q[i] <= '0;
      end
    end else begin
      pend_q <= pend_d;
      ovf_q <= ovf_d;
      for (int i = 0; i < NCH; i++) if (cap[i]) begin
        sd_q[i] <= c_diff[i*DATASIZE +: DATASIZE];
        sc_q[i] <= c_diff_count[i*COUNTSIZE +: COUNTSIZE];
      end
    end
  end
  // issue FSM: grant in IDLE, one pulse cycle, then hold off until the crossing is free
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    rr_d = rr_q;
    det_d = 1'b0;
    dout_d = dout_q;
    cout_d = cout_q;
    chan_d = chan_q;
    unique case (state_q)
      IDLE: if (gnt_valid) begin
        det_d = 1'b1;
        dout_d = sd_q[gnt_idx];
        cout_d = sc_q[gnt_idx];
        chan_d = gnt_idx;
        rr_d = gnt_idx;
        state_d = ISSUE;
      end
      ISSUE: begin
        cnt_d = GAP_CW'(1);
        state_d = (cnt_d == GAP_CW'(ISSUE_GAP - 1)) ? IDLE : GAP;
      end
      GAP: begin
        cnt_d = cnt_q + GAP_CW'(1);
        state_d = (cnt_d == GAP_CW'(ISSUE_GAP - 1)) ? IDLE : GAP;
      end
      default: state_d = IDLE;
    endcase
  end
  // FSM and output registers
  always_ff @(posedge c_clk or posedge c_rst) begin
    if (c_rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rr_q <= CHW'(NCH - 1);
      det_q <= 1'b0;
      dout_q <= '0;
      cout_q <= '0;
      chan_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rr_q <= rr_d;
      det_q <= det_d;
      dout_q <= dout_d;
      cout_q <= cout_d;
      chan_q <= chan_d;
    end
  end
  assign c_detect_out = det_q;
  assign c_diff_out = dout_q;
  assign c_diff_count_out = cout_q;
  assign c_chan_out = chan_q;
  assign c_overflow = ovf_q;
  assign c_busy = (state_q == ISSUE) || (state_q == GAP);
endmodule

// File: tb/tb_c_detect_sched.sv
// tb_c_detect_sched: directed vectors and corner sequences for c_detect_sched
module tb_c_detect_sched;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] det, en;
  logic [63:0] diff;
  logic [127:0] dcnt;
  logic ovf_clr;
  logic det_out, busy;
  logic [15:0] diff_out;
  logic [31:0] cnt_out;
  logic [1:0] chan_out;
  logic [3:0] ovf;
  int n_cmp = 0;
  int n_err = 0;
  c_detect_sched dut (
    .c_clk(clk), .c_rst(rst), .c_detect(det), .c_diff(diff), .c_diff_count(dcnt),
    .c_chan_en(en), .c_ovf_clr(ovf_clr), .c_detect_out(det_out), .c_diff_out(diff_out),
    .c_diff_count_out(cnt_out), .c_chan_out(chan_out), .c_overflow(ovf), .c_busy(busy)
  );
  always #5 clk = ~clk;
  typedef struct {
    int ch;
    logic [3:0] en;
    logic [15:0] d;
    logic [31:0] c;
    bit issue;
  } vec_t;
  vec_t vt[6];
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask
  task automatic set_data(input int ch, input logic [15:0] d, input logic [31:0] c);
    diff[ch*16 +: 16] = d;
    dcnt[ch*32 +: 32] = c;
  endtask
  task automatic pulse(input logic [3:0] m);
    det = m;
    tick();
    det = '0;
  endtask
  task automatic wait_issue(input string nm);
    int k = 0;
    while (!det_out && k < 40) begin
      tick();
      k++;
    end
    chk({nm, "_seen"}, det_out, 1);
  endtask
  task automatic wait_idle(input string nm);
    int k = 0;
    while (busy && k < 40) begin
      tick();
      k++;
    end
    chk({nm, "_idle"}, busy, 0);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask
  task automatic burst(input string nm);
    bit e;
    for (int i = 0; i < 4; i++) set_data(i, 16'h10 + 16'(i), 32'd100 + 32'(i));
    pulse(4'hF);
    for (int c = 1; c <= 46; c++) begin
      e = (c >= 2) && (c <= 44) && ((c - 2) % 14 == 0);
      chk($sformatf("%s_det_c%0d", nm, c), det_out, e);
      if (e) begin
        chk($sformatf("%s_chan_c%0d", nm, c), chan_out, (c - 2) / 14);
        chk($sformatf("%s_diff_c%0d", nm, c), diff_out, 16'h10 + 16'((c - 2) / 14));
      end
      tick();
    end
  endtask
  initial begin
    int n;
    vt[0] = '{0, 4'hF, 16'h1234, 32'd5, 1'b1};
    vt[1] = '{1, 4'hF, 16'hFFFF, 32'hFFFF_FFFF, 1'b1};
    vt[2] = '{3, 4'hF, 16'h0000, 32'd0, 1'b1};
    vt[3] = '{2, 4'b1011, 16'hBEEF, 32'd9, 1'b0};
    vt[4] = '{3, 4'b0111, 16'h5555, 32'd77, 1'b0};
    vt[5] = '{2, 4'hF, 16'h00A5, 32'd1000, 1'b1};
    rst = 1'b1;
    det = '0;
    en = 4'hF;
    diff = '0;
    dcnt = '0;
    ovf_clr = 1'b0;
    #1;
    chk("rst_det", det_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_chan", chan_out, 0);
    chk("rst_diff", diff_out, 0);
    chk("rst_cnt", cnt_out, 0);
    tick();
    tick();
    rst = 1'b0;
    for (int v = 0; v < 6; v++) begin
      wait_idle($sformatf("v%0d", v));
      en = vt[v].en;
      set_data(vt[v].ch, vt[v].d, vt[v].c);
      pulse(4'(1) << vt[v].ch);
      chk($sformatf("v%0d_det_t1", v), det_out, 0);
      tick();
      chk($sformatf("v%0d_det_t2", v), det_out, vt[v].issue);
      if (vt[v].issue) begin
        chk($sformatf("v%0d_chan", v), chan_out, vt[v].ch);
        chk($sformatf("v%0d_diff", v), diff_out, vt[v].d);
        chk($sformatf("v%0d_cnt", v), cnt_out, vt[v].c);
      end
      tick();
      chk($sformatf("v%0d_det_t3", v), det_out, 0);
      repeat (11) tick();
      chk($sformatf("v%0d_busy_p12", v), busy, vt[v].issue);
      tick();
      tick();
      chk($sformatf("v%0d_busy_p14", v), busy, 0);
      chk($sformatf("v%0d_ovf", v), ovf, 0);
      if (vt[v].issue) chk($sformatf("v%0d_hold", v), diff_out, vt[v].d);
      en = 4'hF;
    end
    do_reset();
    burst("b1");
    wait_idle("b1");
    burst("b2");
    wait_idle("b2");
    set_data(0, 16'hA0, 32'd1);
    pulse(4'b0001);
    wait_issue("ov_ch0");
    tick();
    tick();
    set_data(1, 16'd1, 32'd11);
    pulse(4'b0010);
    tick();
    set_data(1, 16'd2, 32'd22);
    pulse(4'b0010);
    chk("ov_flag_early", ovf, 4'b0010);
    wait_issue("ov_ch1");
    chk("ov_chan", chan_out, 1);
    chk("ov_diff", diff_out, 16'd1);
    chk("ov_flag", ovf, 4'b0010);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ov_clr", ovf, 0);
    wait_idle("sc");
    pulse(4'b0001);
    wait_issue("sc_ch0");
    tick();
    set_data(1, 16'd5, 32'd55);
    pulse(4'b0010);
    wait_idle("sc_grant");
    set_data(1, 16'd7, 32'd77);
    pulse(4'b0010);
    chk("sc_det1", det_out, 1);
    chk("sc_chan1", chan_out, 1);
    chk("sc_diff1", diff_out, 16'd5);
    repeat (13) tick();
    chk("sc_det_gap", det_out, 0);
    tick();
    chk("sc_det2", det_out, 1);
    chk("sc_diff2", diff_out, 16'd7);
    chk("sc_cnt2", cnt_out, 32'd77);
    chk("sc_ovf", ovf, 0);
    wait_idle("en");
    pulse(4'b0001);
    wait_issue("en_ch0");
    tick();
    tick();
    set_data(3, 16'h33, 32'd333);
    pulse(4'b1000);
    en = 4'b0111;
    wait_issue("en_ch3");
    chk("en_chan", chan_out, 3);
    chk("en_diff", diff_out, 16'h33);
    en = 4'hF;
    wait_idle("rm");
    set_data(2, 16'h22, 32'd2);
    pulse(4'b0100);
    wait_issue("rm_ch2");
    tick();
    pulse(4'b0011);
    tick();
    chk("rm_busy_pre", busy, 1);
    chk("rm_chan_pre", chan_out, 2);
    rst = 1'b1;
    #1;
    chk("rm_busy", busy, 0);
    chk("rm_chan", chan_out, 0);
    chk("rm_diff", diff_out, 0);
    chk("rm_det", det_out, 0);
    tick();
    rst = 1'b0;
    n = 0;
    repeat (20) begin
      tick();
      if (det_out) n++;
    end
    chk("rm_no_issue", n, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
